// File: rtl/enemy_bullet_rx.sv
// Receive side of the shot link: tracks the opponent bullet, draws it, scores hits on the local tank.
// Optional hit flash on the local tank box when ENEMY_BULLET_HIT_FLASH_EN is defined.
module enemy_bullet_rx #(
  parameter int TANK_SIZE    = 48,
  parameter int BULLET_LEN   = 11,
  parameter int BULLET_WID   = 5,
  parameter int HEALTH_INIT  = 3,
  parameter int TIMEOUT      = 1300000,
  parameter int FLASH_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hblnk,
  input  logic        vblnk,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [11:0] rgb,
  input  logic [9:0]  xpos_t,
  input  logic [9:0]  ypos_t,
  input  logic [9:0]  xpos_bullet_op,
  input  logic [9:0]  ypos_bullet_op,
  input  logic [2:0]  direction_op,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic [11:0] rgb_out,
  output logic        hit,
  output logic [3:0]  health,
  output logic        dead,
  output logic        bullet_active
);

  localparam int HL = (BULLET_LEN - 1) / 2;
  localparam int HW = (BULLET_WID - 1) / 2;
  localparam logic [20:0] STALE_LAST = 21'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, TRACK, HIT, BLOCK} state_t;

  state_t      state, state_nxt;
  logic [9:0]  xb, yb;
  logic [2:0]  dir, dir_in;
  logic [20:0] stale;
  logic        latch_en, in_change, hit_test;

  assign dir_in    = (direction_op > 3'd4) ? 3'd0 : direction_op;
  assign latch_en  = (state == IDLE) || (state == TRACK);
  assign in_change = (xpos_bullet_op != xb) || (ypos_bullet_op != yb) || (dir_in != dir);

  // Hit box compared in 11 bits so the upper bound never wraps
  logic [10:0] tx_hi, ty_hi;
  assign tx_hi = {1'b0, xpos_t} + 11'(TANK_SIZE - 1);
  assign ty_hi = {1'b0, ypos_t} + 11'(TANK_SIZE - 1);
  assign hit_test = ({1'b0, xb} >= {1'b0, xpos_t}) && ({1'b0, xb} <= tx_hi) &&
                    ({1'b0, yb} >= {1'b0, ypos_t}) && ({1'b0, yb} <= ty_hi);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      xb    <= '0;
      yb    <= '0;
      dir   <= '0;
      stale <= '0;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        xb  <= xpos_bullet_op;
        yb  <= ypos_bullet_op;
        dir <= dir_in;
      end
      if (state != TRACK || in_change) stale <= '0;
      else                             stale <= stale + 21'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (dir != 3'd0 && !dead) state_nxt = TRACK;
      TRACK: begin
        if (dir == 3'd0)               state_nxt = IDLE;
        else if (stale == STALE_LAST)  state_nxt = IDLE;
        else if (hit_test)             state_nxt = HIT;
      end
      HIT:   state_nxt = BLOCK;
      // latched dir is frozen here, so release follows the live stream
      BLOCK: if (dir_in == 3'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit           <= 1'b0;
      health        <= 4'(HEALTH_INIT);
      dead          <= 1'b0;
      bullet_active <= 1'b0;
    end else begin
      hit           <= (state_nxt == HIT);
      bullet_active <= (state_nxt == TRACK);
      if (state_nxt == HIT) begin
        if (health != 4'd0) health <= health - 4'd1;
        if (health <= 4'd1) dead   <= 1'b1;
      end
    end
  end

  // Drawing in 12 bits: hcount+HW cannot overflow at the right edge
  logic [11:0] hc, vc, bx, by;
  logic        vert, horiz, on_v, on_h, draw, flash;
  assign hc    = {1'b0, hcount};
  assign vc    = {2'b0, vcount};
  assign bx    = {2'b0, xb};
  assign by    = {2'b0, yb};
  assign vert  = (dir == 3'd1) || (dir == 3'd2);
  assign horiz = (dir == 3'd3) || (dir == 3'd4);
  assign on_v  = vert  && (hc + 12'(HW) >= bx) && (hc <= bx + 12'(HW)) &&
                          (vc + 12'(HL) >= by) && (vc <= by + 12'(HL));
  assign on_h  = horiz && (hc + 12'(HL) >= bx) && (hc <= bx + 12'(HL)) &&
                          (vc + 12'(HW) >= by) && (vc <= by + 12'(HW));
  assign draw  = (state == TRACK) && (on_v || on_h);

`ifdef ENEMY_BULLET_HIT_FLASH_EN
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  logic [FW-1:0] flash_cnt;
  logic          vblnk_d, in_tank;

  always_ff @(posedge clk) begin
    if (rst) begin
      flash_cnt <= '0;
      vblnk_d   <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
      if (state_nxt == HIT)                             flash_cnt <= FW'(FLASH_FRAMES);
      else if (vblnk && !vblnk_d && flash_cnt != '0)    flash_cnt <= flash_cnt - 1'b1;
    end
  end

  assign in_tank = (hc >= {2'b0, xpos_t}) && (hc <= {1'b0, tx_hi}) &&
                   (vc >= {2'b0, ypos_t}) && (vc <= {1'b0, ty_hi});
  assign flash   = (flash_cnt != '0) && flash_cnt[0] && in_tank;
`else
  assign flash = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      rgb_out    <= '0;
    end else begin
      hblnk_out  <= hblnk;
      vblnk_out  <= vblnk;
      hsync_out  <= hsync;
      vsync_out  <= vsync;
      hcount_out <= hcount;
      vcount_out <= vcount;
      if (draw)       rgb_out <= 12'hF00;
      else if (flash) rgb_out <= 12'hFFF;
      else            rgb_out <= rgb;
    end
  end

endmodule

// File: tb/tb_enemy_bullet_rx.sv
// Scoreboard bench for enemy_bullet_rx: video model queue plus hit/health/timeout scenarios.
module tb_enemy_bullet_rx;

  localparam int HL = 5;
  localparam int HW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        hblnk, vblnk, hsync, vsync;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [11:0] rgb;
  logic [9:0]  xpos_t, ypos_t, xpos_bullet_op, ypos_bullet_op;
  logic [2:0]  direction_op;
  logic        hblnk_out, vblnk_out, hsync_out, vsync_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [11:0] rgb_out;
  logic        hit, dead, bullet_active;
  logic [3:0]  health;

  enemy_bullet_rx #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst),
    .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
    .hcount(hcount), .vcount(vcount), .rgb(rgb),
    .xpos_t(xpos_t), .ypos_t(ypos_t),
    .xpos_bullet_op(xpos_bullet_op), .ypos_bullet_op(ypos_bullet_op),
    .direction_op(direction_op),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .rgb_out(rgb_out),
    .hit(hit), .health(health), .dead(dead), .bullet_active(bullet_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic [24:0] tim;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_bx, m_by;
  bit   m_horiz, m_toggle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_px(input int h, input int v, input logic [11:0] c);
    bit in;
    if (m_horiz) in = (h >= m_bx - HL) && (h <= m_bx + HL) && (v >= m_by - HW) && (v <= m_by + HW);
    else         in = (h >= m_bx - HW) && (h <= m_bx + HW) && (v >= m_by - HL) && (v <= m_by + HL);
    return in ? 12'hF00 : c;
  endfunction

  // bullet model only matters while m_toggle keeps the DUT tracking; elsewhere pixels sit outside it
  task automatic px(input int h, input int v, input logic [11:0] c, input bit draw_on);
    exp_t e;
    hcount = 11'(h); vcount = 10'(v); rgb = c;
    hblnk = 1'($urandom); vblnk = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
    e.rgb = draw_on ? exp_px(h, v, c) : c;
    e.tim = {hblnk, vblnk, hsync, vsync, hcount, vcount};
    q.push_back(e);
    if (m_toggle) direction_op = (direction_op == 3'd3) ? 3'd4 : 3'd3;
    tick();
    e = q.pop_front();
    chk("rgb", {20'd0, rgb_out}, {20'd0, e.rgb});
    chk("tim", {7'd0, hblnk_out, vblnk_out, hsync_out, vsync_out, hcount_out, vcount_out}, {7'd0, e.tim});
  endtask

  task automatic shoot(input int exp_health, input bit exp_dead);
    int got = 0;
    xpos_bullet_op = 10'd124; ypos_bullet_op = 10'd120; direction_op = 3'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      got += int'(hit);
    end
    chk("shot_hit", got, 1);
    chk("shot_health", health, exp_health);
    chk("shot_dead", dead, exp_dead);
    direction_op = 3'd0;
    repeat (3) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int hits, hit_y, act, cnt;
    rst = 1'b1; hblnk = 1'b0; vblnk = 1'b0; hsync = 1'b0; vsync = 1'b0;
    hcount = 11'd5; vcount = 10'd7; rgb = 12'hABC;
    xpos_t = 10'd600; ypos_t = 10'd400;
    xpos_bullet_op = '0; ypos_bullet_op = '0; direction_op = 3'd0;
    m_toggle = 1'b0; m_horiz = 1'b1; m_bx = 0; m_by = 0;
    tick(); tick();
    chk("rst_rgb", rgb_out, 0);
    chk("rst_hcount", hcount_out, 0);
    chk("rst_hit", hit, 0);
    chk("rst_health", health, 3);
    chk("rst_dead", dead, 0);
    chk("rst_active", bullet_active, 0);
    rst = 1'b0;

    // pass-through with no shot
    for (int i = 0; i < 20; i++) begin
      px($urandom_range(0, 2047), $urandom_range(0, 1023), 12'($urandom), 1'b0);
      chk("idle_hit", hit, 0);
    end

    // descending bullet into tank at (100,100)
    xpos_t = 10'd100; ypos_t = 10'd100;
    xpos_bullet_op = 10'd124; direction_op = 3'd1;
    hits = 0; hit_y = -1;
    for (int y = 300; y >= 140; y--) begin
      ypos_bullet_op = 10'(y);
      tick();
      if (hit) begin hits++; hit_y = y; end
    end
    chk("hit_count", hits, 1);
    chk("hit_y", hit_y, 146);
    chk("hit_health", health, 2);
    chk("block_active", bullet_active, 0);
    ypos_bullet_op = 10'd120;
    hits = 0;
    for (int i = 0; i < 6; i++) begin tick(); hits += int'(hit); end
    chk("block_nohit", hits, 0);
    direction_op = 3'd0;
    repeat (3) tick();
    ypos_bullet_op = 10'd500; direction_op = 3'd1;
    repeat (3) tick();
    chk("rearm_active", bullet_active, 1);
    direction_op = 3'd0;
    repeat (3) tick();

    // horizontal bullet scan at (40,200), dir alternating 3/4 keeps it live
    xpos_t = 10'd600; ypos_t = 10'd400;
    xpos_bullet_op = 10'd40; ypos_bullet_op = 10'd200; direction_op = 3'd3;
    m_bx = 40; m_by = 200; m_horiz = 1'b1; m_toggle = 1'b1;
    for (int i = 0; i < 4; i++) px(1000, 0, 12'h123, 1'b1);
    for (int v = 195; v <= 205; v++)
      for (int h = 30; h <= 50; h++) px(h, v, 12'($urandom_range(0, 4095)), 1'b1);

    // clipping at the top-left corner
    xpos_bullet_op = 10'd3; ypos_bullet_op = 10'd3; direction_op = 3'd4;
    m_bx = 3; m_by = 3;
    for (int i = 0; i < 4; i++) px(1000, 500, 12'h456, 1'b1);
    for (int v = 0; v <= 7; v++) begin
      for (int h = 2040; h <= 2047; h++) px(h, v, 12'h0A5, 1'b1);
      for (int h = 0; h <= 12; h++)      px(h, v, 12'h0A5, 1'b1);
    end
    m_toggle = 1'b0; direction_op = 3'd0;
    repeat (3) tick();

    // remaining two hits down to dead
    xpos_t = 10'd100; ypos_t = 10'd100;
    shoot(1, 1'b0);
    shoot(0, 1'b1);
    xpos_bullet_op = 10'd124; ypos_bullet_op = 10'd120; direction_op = 3'd1;
    act = 0; hits = 0;
    for (int i = 0; i < 10; i++) begin tick(); act += int'(bullet_active); hits += int'(hit); end
    chk("dead_active", act, 0);
    chk("dead_hit", hits, 0);
    chk("dead_health", health, 0);
    chk("dead_sticky", dead, 1);
    direction_op = 3'd0;

    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_health", health, 3);
    chk("rst2_dead", dead, 0);

    // frozen stream times out after TIMEOUT cycles
    xpos_t = 10'd600; ypos_t = 10'd400;
    xpos_bullet_op = 10'd200; ypos_bullet_op = 10'd200; direction_op = 3'd2;
    cnt = 0;
    while (!bullet_active && cnt < 10) begin tick(); cnt++; end
    chk("to_enter", bullet_active, 1);
    cnt = 0;
    while (bullet_active && cnt < 300) begin tick(); cnt++; end
    chk("to_cycles", cnt, 100);
    direction_op = 3'd0;
    repeat (3) tick();

    // reset while in HIT
    xpos_t = 10'd100; ypos_t = 10'd100;
    xpos_bullet_op = 10'd124; ypos_bullet_op = 10'd120; direction_op = 3'd1;
    cnt = 0;
    while (!hit && cnt < 10) begin tick(); cnt++; end
    chk("rsthit_seen", hit, 1);
    chk("rsthit_pre_health", health, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rsthit_active", bullet_active, 0);
    chk("rsthit_hit", hit, 0);
    chk("rsthit_health", health, 3);
    chk("rsthit_dead", dead, 0);
    direction_op = 3'd0;
    tick();
    chk("rsthit_hit2", hit, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
